// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes 11-bit frames with odd parity,
// and tracks which of the W/A/S/D/space keys is currently held.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [3:0] key_press,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       code_strobe,
    output logic       frame_err
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          r_clkMeta;
    logic          r_clkSync;
    logic          r_clkPrev;
    logic          r_datMeta;
    logic          r_datSync;
    logic [3:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_timeout;
    logic          r_breakPending;
    logic          r_extPending;
    logic          w_fallEdge;
    logic          w_timeout;
    logic          w_byteGood;
    logic          w_frameErr;
    logic [3:0]    w_mapped;
    logic [3:0]    w_nextKey;

    // Synchroniser flops idle at 1 so reset release never looks like a falling edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clkMeta <= 1'b1;
            r_clkSync <= 1'b1;
            r_clkPrev <= 1'b1;
            r_datMeta <= 1'b1;
            r_datSync <= 1'b1;
        end else begin
            r_clkMeta <= PS2_CLK;
            r_clkSync <= r_clkMeta;
            r_clkPrev <= r_clkSync;
            r_datMeta <= PS2_DAT;
            r_datSync <= r_datMeta;
        end
    end

    assign w_fallEdge = r_clkPrev & ~r_clkSync;
    assign w_timeout  = (r_state != S_IDLE) && !w_fallEdge && (r_timeout == TIMEOUT_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_byteGood  = 1'b0;
        w_frameErr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fallEdge && !r_datSync) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fallEdge && (r_bitCnt == 4'd7)) begin
                    w_nextState = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fallEdge) begin
                    w_nextState = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fallEdge) begin
                    w_nextState = S_IDLE;
                    if (r_datSync && (^{r_shift, r_parity})) begin
                        w_byteGood = 1'b1;
                    end else begin
                        w_frameErr = 1'b1;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (w_timeout) begin
            w_nextState = S_IDLE;
            w_frameErr  = 1'b1;
        end
    end

    // Data bits arrive LSB first, so shift right and insert at the top.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bitCnt  <= 4'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_timeout <= '0;
        end else begin
            if (r_state == S_IDLE || w_fallEdge) begin
                r_timeout <= '0;
            end else if (r_timeout != TIMEOUT_LAST) begin
                r_timeout <= r_timeout + TW'(1);
            end
            if (r_state == S_IDLE) begin
                r_bitCnt <= 4'd0;
            end else if (r_state == S_DATA && w_fallEdge) begin
                r_shift  <= {r_datSync, r_shift[7:1]};
                r_bitCnt <= r_bitCnt + 4'd1;
            end
            if (r_state == S_PARITY && w_fallEdge) begin
                r_parity <= r_datSync;
            end
        end
    end

    always_comb begin
        w_mapped = 4'd0;
        case (r_shift)
            8'h1C:   w_mapped = 4'd1;
            8'h23:   w_mapped = 4'd2;
            8'h1B:   w_mapped = 4'd3;
            8'h1D:   w_mapped = 4'd4;
            8'h29:   w_mapped = 4'd5;
            default: w_mapped = 4'd0;
        endcase
    end

    // A break only releases the key it names; extended-prefix bytes never touch the held key.
    always_comb begin
        w_nextKey = key_press;
        if (r_shift != 8'hF0 && r_shift != 8'hE0 && !r_extPending && w_mapped != 4'd0) begin
            if (r_breakPending) begin
                if (w_mapped == key_press) begin
                    w_nextKey = 4'd0;
                end
            end else begin
                w_nextKey = w_mapped;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_press      <= 4'd0;
            key_valid      <= 1'b0;
            scan_code      <= 8'h00;
            code_strobe    <= 1'b0;
            frame_err      <= 1'b0;
            r_breakPending <= 1'b0;
            r_extPending   <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            code_strobe <= 1'b0;
            frame_err   <= 1'b0;
            if (w_byteGood) begin
                scan_code   <= r_shift;
                code_strobe <= 1'b1;
                key_press   <= w_nextKey;
                key_valid   <= (w_nextKey != key_press);
                if (r_shift == 8'hF0) begin
                    r_breakPending <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_extPending <= 1'b1;
                end else begin
                    r_breakPending <= 1'b0;
                    r_extPending   <= 1'b0;
                end
            end
            if (w_frameErr) begin
                frame_err      <= 1'b1;
                r_breakPending <= 1'b0;
                r_extPending   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of frames plus hand-written timeout and mid-frame reset sequences,
// with every strobe/error event checked against a queue of expected results.
module tb_ps2_key_decoder;

    localparam int TIMEOUT = 100;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [3:0] key_press;
    logic       key_valid;
    logic [7:0] scan_code;
    logic       code_strobe;
    logic       frame_err;

    typedef struct {
        logic       isErr;
        logic [7:0] scan;
        logic [3:0] key;
        logic       valid;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       badParity;
        logic       badStop;
        logic       expErr;
        logic [7:0] expScan;
        logic [3:0] expKey;
        logic       expValid;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[19];
    int   checks = 0;
    int   errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .key_press   (key_press),
        .key_valid   (key_valid),
        .scan_code   (scan_code),
        .code_strobe (code_strobe),
        .frame_err   (frame_err)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic sendBit(input logic b);
        PS2_DAT = b;
        waitCycles(10);
        PS2_CLK = 1'b0;
        waitCycles(20);
        PS2_CLK = 1'b1;
        waitCycles(10);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic badParity, input logic badStop);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(data[i]);
        end
        sendBit((~^data) ^ badParity);
        sendBit(~badStop);
    endtask

    task automatic pushExp(input logic isErr, input logic [7:0] scan, input logic [3:0] key, input logic valid);
        exp_t e;
        e.isErr = isErr;
        e.scan  = scan;
        e.key   = key;
        e.valid = valid;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        pushExp(v.expErr, v.expScan, v.expKey, v.expValid);
        sendFrame(v.data, v.badParity, v.badStop);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            waitCycles(1);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: %0d expected events never seen, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Every DUT event consumes one expected record; an event with nothing queued is an error.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (!reset && (code_strobe || frame_err || key_valid)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: strobe=%0b err=%0b valid=%0b, expected no event",
                         code_strobe, frame_err, key_valid);
            end else begin
                e = expQ.pop_front();
                checkOutput("frame_err", 8'(frame_err), 8'(e.isErr));
                checkOutput("code_strobe", 8'(code_strobe), 8'(!e.isErr));
                checkOutput("scan_code", scan_code, e.scan);
                checkOutput("key_press", 8'(key_press), 8'(e.key));
                checkOutput("key_valid", 8'(key_valid), 8'(e.valid));
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           data   badP  badS  err   scan   key   valid
        vecs[0]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h1D, 4'd4, 1'b1};
        vecs[1]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h1D, 4'd4, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 4'd4, 1'b0};
        vecs[3]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h1D, 4'd0, 1'b1};
        vecs[4]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h1D, 4'd4, 1'b1};
        vecs[5]  = '{8'h23, 1'b0, 1'b0, 1'b0, 8'h23, 4'd2, 1'b1};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 4'd2, 1'b0};
        vecs[7]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h1D, 4'd2, 1'b0};
        vecs[8]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 8'h1D, 4'd2, 1'b0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'hE0, 4'd2, 1'b0};
        vecs[10] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 4'd2, 1'b0};
        vecs[11] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 4'd1, 1'b1};
        vecs[12] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 4'd1, 1'b0};
        vecs[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 4'd1, 1'b0};
        vecs[14] = '{8'h23, 1'b1, 1'b0, 1'b1, 8'hF0, 4'd1, 1'b0};
        vecs[15] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 4'd1, 1'b0};
        vecs[16] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 4'd1, 1'b0};
        vecs[17] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 4'd0, 1'b1};
        vecs[18] = '{8'h29, 1'b0, 1'b1, 1'b1, 8'h1C, 4'd0, 1'b0};

        reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        waitCycles(5);
        checkOutput("reset_key_press", 8'(key_press), 8'h00);
        checkOutput("reset_scan_code", scan_code, 8'h00);
        checkOutput("reset_strobes", 8'({key_valid, code_strobe, frame_err}), 8'h00);
        reset = 1'b0;
        waitCycles(20);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            waitDrain($sformatf("vector_%0d", i), 200);
        end

        // Partial frame (start + 4 data bits) then silence: the timeout must abandon it.
        pushExp(1'b1, 8'h1C, 4'd0, 1'b0);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) begin
            sendBit(i[0]);
        end
        waitDrain("timeout_err", 3 * TIMEOUT);
        pushExp(1'b0, 8'h29, 4'd5, 1'b1);
        sendFrame(8'h29, 1'b0, 1'b0);
        waitDrain("after_timeout", 200);

        // Reset while the clock line is low during the fourth data bit.
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        PS2_DAT = 1'b1;
        waitCycles(10);
        PS2_CLK = 1'b0;
        waitCycles(5);
        reset = 1'b1;
        #1;
        checkOutput("midreset_key_press", 8'(key_press), 8'h00);
        checkOutput("midreset_scan_code", scan_code, 8'h00);
        checkOutput("midreset_strobes", 8'({key_valid, code_strobe, frame_err}), 8'h00);
        PS2_CLK = 1'b1;
        waitCycles(10);
        reset = 1'b0;
        waitCycles(50);
        pushExp(1'b0, 8'h1B, 4'd3, 1'b1);
        sendFrame(8'h1B, 1'b0, 1'b0);
        waitDrain("after_reset", 200);

        waitCycles(50);
        checkOutput("queue_empty", 8'(expQ.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
